multiport_reg_file: RTL and testbench
=====================================

Name: multiport_reg_file

Overview:
- Parametrised register file: DEPTH words of WIDTH bits, one write port, NUM_RD independent combinational read ports.
- Adds features the earlier register file lacked:
  - write-through bypass on every read port;
  - optional hardwired-zero register 0;
  - a sequential clear-sweep engine that zeroes the array one word per cycle under a req/busy/done handshake.
- Sits in the CPU decode stage; feeds operand muxes and is written from writeback.

Parameters:
- WIDTH, 16, bits per register word.
- DEPTH, 16, number of registers; power of two, minimum 2.
- NUM_RD, 2, number of read ports, 1 to 4.
- ZERO_R0, 1, if 1 then register 0 always reads 0 and ignores writes.
- BYPASS, 1, if 1 then a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  clock, rising edge active
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  write request this cycle
- wr_addr  input  AW  write address; AW = clog2(DEPTH)
- wr_data  input  WIDTH  write data
- wr_drop  output  1  pulses high for one cycle when wr_en is ignored because a sweep is active
- rd_addr  input  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW]
- rd_data  output  NUM_RD*WIDTH  packed read data; port i occupies bits [i*WIDTH +: WIDTH]
- clr_req  input  1  start a clear sweep; sampled only in IDLE
- clr_busy  output  1  high while a sweep is in progress
- clr_done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (rst=0, asynchronous):
  - all words become 0;
  - FSM goes to IDLE and the sweep pointer to 0;
  - clr_busy, clr_done and wr_drop are 0.
  - Reset asserted mid-sweep aborts the sweep immediately; no clr_done is issued.
- Writes:
  - On the rising edge with wr_en=1 and FSM not in SWEEP, mem[wr_addr] <= wr_data.
  - With ZERO_R0=1, a write to address 0 has no effect and does not raise wr_drop.
- Reads:
  - Zero latency; each port is an independent combinational function of its address.
  - Priority for rd_data[i]:
    1. ZERO_R0=1 and rd_addr[i]=0: output 0.
    2. BYPASS=1, wr_en=1, FSM not in SWEEP, rd_addr[i]=wr_addr: output wr_data.
    3. Otherwise: output mem[rd_addr[i]].
  - BYPASS=0: a same-cycle write is visible on the read port only after the edge.
- Multiple read ports may present the same address; all return identical data.
- Clear FSM, states IDLE, SWEEP, DONE:
  - IDLE: clr_req=1 moves to SWEEP with ptr=0 on the next edge. clr_busy goes high in the cycle after the request is sampled.
  - SWEEP: each edge sets mem[ptr] <= 0 and ptr <= ptr+1. When ptr=DEPTH-1, that word is cleared and the FSM moves to DONE. The sweep therefore occupies exactly DEPTH cycles with clr_busy=1.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then IDLE.
  - clr_req is ignored in SWEEP and DONE; a request held high re-triggers only once back in IDLE, so the minimum sweep-to-sweep period is DEPTH+2 cycles.
- Interaction with writes and reads during a sweep:
  - While in SWEEP, wr_en=1 is discarded. wr_drop=1 that same cycle, registered out so it is visible in the following cycle.
  - A read during a sweep returns the currently stored value. The word being cleared at an edge still reads its old value in the cycle before that edge and 0 after it.
- Pointer width is AW; it never wraps past DEPTH-1 within a sweep.

Decomposition:
- Package rf_pkg holds:
  - the FSM state typedef (IDLE, SWEEP, DONE), 2-bit encoding;
  - the default WIDTH/DEPTH constants;
  - the function computing AW from DEPTH.
- One natural sub-module, rf_read_port: a single port's address decode plus zero/bypass/array mux, instantiated NUM_RD times via generate.
- The array, write logic and clear FSM live in the top module.

Test Plan:
- Reset then write 0xBEEF to r5; next cycle rd_addr0=5 -> rd_data0=0xBEEF; rd_addr1=3 -> 0x0000.
- Write 0x1234 to r7 with rd_addr0=rd_addr1=7 in the same cycle, BYPASS=1 -> both ports show 0x1234 that cycle. With BYPASS=0 -> both show the old value, then 0x1234 after the edge.
- ZERO_R0=1: write 0xFFFF to r0 -> rd_data for address 0 stays 0 and wr_drop stays 0.
- Fill all 16 registers with 0xA5A5 and pulse clr_req:
  - clr_busy high for exactly 16 cycles, then clr_done for 1 cycle;
  - r15 reads 0xA5A5 until the final sweep edge;
  - all reads are 0 afterwards.
- During a sweep, issue wr_en to r2 with 0x5555 -> wr_drop=1 for one cycle; r2 reads 0 after the sweep.
- Pull rst low at sweep cycle 6 -> clr_busy=0 immediately, all words 0, no clr_done; a new clr_req afterwards runs a full 16-cycle sweep.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
//   - clr_state_e : clear-sweep FSM states (2-bit encoding)
//   - DEF_WIDTH / DEF_DEPTH : default word width and register count
//   - calc_aw() : address width for a given depth (at least 1 bit)
package rf_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } clr_state_e;

    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   rd_addr  - read address
//   fwd_en   - a write is committing this cycle (wr_en and not sweeping)
//   wr_addr  - write address, for bypass match
//   wr_data  - write data, forwarded on match
//   mem_flat - whole array, word i at [i*WIDTH +: WIDTH]
//   rd_data  - read result
module rf_read_port #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic [AW-1:0]          rd_addr,
    input  logic                   fwd_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    output logic [WIDTH-1:0]       rd_data
);

    logic [WIDTH-1:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign words[i] = mem_flat[i*WIDTH +: WIDTH];
    end

    // Priority: hardwired zero, then same-cycle forwarding, then stored word.
    always_comb begin
        rd_data = words[rd_addr];
        if (ZERO_R0 && (rd_addr == '0)) begin
            rd_data = '0;
        end else if (BYPASS && fwd_en && (rd_addr == wr_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/multiport_reg_file.sv
// Register file: DEPTH x WIDTH, one write port, NUM_RD combinational read ports,
// optional write-through bypass, optional hardwired-zero r0, and a clear sweep
// engine that zeroes one word per cycle.
// Ports:
//   clk, rst              - clock (rising edge), async active-low reset
//   wr_en/wr_addr/wr_data - write port
//   wr_drop               - registered flag: previous cycle's write was discarded by a sweep
//   rd_addr/rd_data       - packed read ports, port i at [i*AW +: AW] / [i*WIDTH +: WIDTH]
//   clr_req               - start a sweep (sampled in idle only)
//   clr_busy/clr_done     - sweep in progress / one-cycle completion pulse
module multiport_reg_file
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned NUM_RD  = 2,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned AW     = calc_aw(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    wr_drop,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    clr_state_e             state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   wr_drop_q, wr_drop_d;
    logic                   sweeping;
    logic                   wr_commit;

    assign sweeping  = (state_q == StSweep);
    assign wr_commit = wr_en && !sweeping && !(ZERO_R0 && (wr_addr == '0));
    // A write to a hardwired-zero r0 is a no-op, not a drop.
    assign wr_drop_d = wr_en && sweeping && !(ZERO_R0 && (wr_addr == '0));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                if (ptr_q == AW'(DEPTH - 1)) begin
                    // Hold the pointer on the last word; it never wraps within a sweep.
                    state_d = StDone;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q   <= StIdle;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
            if (sweeping) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_commit) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign clr_busy = sweeping;
    assign clr_done = (state_q == StDone);
    assign wr_drop  = wr_drop_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
        ) u_rd (
            .rd_addr  (rd_addr[p*AW +: AW]),
            .fwd_en   (wr_en && !sweeping),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem_flat (mem_flat),
            .rd_data  (rd_data[p*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multiport_reg_file.sv
module tb_multiport_reg_file;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [2*AW-1:0] rd_addr;
    logic          clr_req;
    logic          a_wr_drop, a_clr_busy, a_clr_done;
    logic          b_wr_drop, b_clr_busy, b_clr_done;
    logic [2*W-1:0] a_rd_data, b_rd_data;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: defaults (zero r0, bypass on). Instance B: no zero r0, no bypass.
    multiport_reg_file #(.WIDTH(W), .DEPTH(D), .NUM_RD(2), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(a_wr_drop), .rd_addr(rd_addr), .rd_data(a_rd_data), .clr_req(clr_req),
        .clr_busy(a_clr_busy), .clr_done(a_clr_done)
    );
    multiport_reg_file #(.WIDTH(W), .DEPTH(D), .NUM_RD(2), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(b_wr_drop), .rd_addr(rd_addr), .rd_data(b_rd_data), .clr_req(clr_req),
        .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays plus "which word is cleared next" during a sweep.
    logic [W-1:0] ma [D];
    logic [W-1:0] mb [D];
    int  sweep_idx;   // -1 when no sweep in progress
    bit  m_done;
    bit  m_drop_a, m_drop_b;

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        sweep_idx = -1;
        m_done    = 1'b0;
        m_drop_a  = 1'b0;
        m_drop_b  = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_a(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wr_en && sweep_idx < 0 && a == wr_addr) return wr_data;
        return ma[a];
    endfunction

    task automatic model_edge();
        bit was_done;
        m_drop_a = wr_en && (sweep_idx >= 0) && (wr_addr != 0);
        m_drop_b = wr_en && (sweep_idx >= 0);
        was_done = m_done;
        m_done   = 1'b0;
        if (sweep_idx >= 0) begin
            ma[sweep_idx] = '0;
            mb[sweep_idx] = '0;
            if (sweep_idx == D - 1) begin
                sweep_idx = -1;
                m_done    = 1'b1;
            end else begin
                sweep_idx++;
            end
        end else begin
            if (wr_en) begin
                if (wr_addr != 0) ma[wr_addr] = wr_data;
                mb[wr_addr] = wr_data;
            end
            if (!was_done && clr_req) sweep_idx = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 2; p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            chk("rd_a", 32'(a_rd_data[p*W +: W]), 32'(exp_a(a)));
            chk("rd_b", 32'(b_rd_data[p*W +: W]), 32'(mb[a]));
        end
        chk("busy_a", 32'(a_clr_busy), 32'(sweep_idx >= 0));
        chk("busy_b", 32'(b_clr_busy), 32'(sweep_idx >= 0));
        chk("done_a", 32'(a_clr_done), 32'(m_done));
        chk("done_b", 32'(b_clr_done), 32'(m_done));
        chk("drop_a", 32'(a_wr_drop), 32'(m_drop_a));
        chk("drop_b", 32'(b_wr_drop), 32'(m_drop_b));
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit we, input int wa, input int wd, input int r0, input int r1,
                          input bit cr);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = W'(wd);
        rd_addr = {AW'(r1), AW'(r0)};
        clr_req = cr;
    endtask

    // Runs a sweep already requested; counts busy cycles until done (bounded).
    task automatic run_sweep(input bit poke_r2);
        int  busy = 0;
        bit  seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            set_in(poke_r2 && c == 3, 2, 16'h5555, 15, 2, 1'b0);
            tick_check();
            if (a_clr_busy) chk("r15_pre", 32'(a_rd_data[W-1:0]), 32'hA5A5);
            if (poke_r2 && c == 4) chk("drop_r2", 32'(a_wr_drop), 32'd1);
            if (a_clr_done) seen_done = 1'b1;
            else if (a_clr_busy) busy++;
            tick_edge();
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("busy_cnt", 32'(busy), 32'd16);
    endtask

    task automatic fill_a5();
        for (int i = 0; i < D; i++) begin
            set_in(1'b1, i, 16'hA5A5, i, 0, 1'b0);
            tick_check();
            tick_edge();
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        set_in(1'b0, 0, 0, 5, 3, 1'b0);
        #12;
        check_outputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Write r5, read back next cycle.
        set_in(1'b1, 5, 16'hBEEF, 5, 3, 1'b0);
        tick_check();
        tick_edge();
        set_in(1'b0, 0, 0, 5, 3, 1'b0);
        tick_check();
        chk("r5", 32'(a_rd_data[W-1:0]), 32'hBEEF);
        chk("r3", 32'(a_rd_data[2*W-1:W]), 32'h0);
        tick_edge();

        // Same-cycle write to r7 on both ports: A forwards, B shows old value.
        set_in(1'b1, 7, 16'h1234, 7, 7, 1'b0);
        tick_check();
        chk("byp_p0", 32'(a_rd_data[W-1:0]), 32'h1234);
        chk("byp_p1", 32'(a_rd_data[2*W-1:W]), 32'h1234);
        chk("nobyp_p0", 32'(b_rd_data[W-1:0]), 32'h0);
        tick_edge();
        set_in(1'b0, 0, 0, 7, 7, 1'b0);
        tick_check();
        chk("nobyp_after", 32'(b_rd_data[2*W-1:W]), 32'h1234);
        tick_edge();

        // Write to r0: A stays zero, no drop.
        set_in(1'b1, 0, 16'hFFFF, 0, 0, 1'b0);
        tick_check();
        chk("r0_same", 32'(a_rd_data[W-1:0]), 32'h0);
        tick_edge();
        set_in(1'b0, 0, 0, 0, 0, 1'b0);
        tick_check();
        chk("r0_after", 32'(a_rd_data[W-1:0]), 32'h0);
        chk("r0_drop", 32'(a_wr_drop), 32'h0);
        tick_edge();

        // Fill, sweep with a dropped write to r2.
        fill_a5();
        set_in(1'b0, 0, 0, 15, 2, 1'b1);
        tick_check();
        tick_edge();
        run_sweep(1'b1);
        for (int i = 0; i < D; i++) begin
            set_in(1'b0, 0, 0, i, i, 1'b0);
            tick_check();
            chk("zero_after", 32'(b_rd_data[W-1:0]), 32'h0);
            tick_edge();
        end

        // Reset in sweep cycle 6.
        fill_a5();
        set_in(1'b0, 0, 0, 15, 2, 1'b1);
        tick_check();
        tick_edge();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, 0, 0, 15, 2, 1'b0);
            tick_check();
            tick_edge();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(a_clr_busy), 32'h0);
        chk("rst_done", 32'(a_clr_done), 32'h0);
        for (int i = 0; i < D; i++) begin
            rd_addr = {AW'(i), AW'(i)};
            #1;
            chk("rst_zero_b", 32'(b_rd_data[W-1:0]), 32'h0);
        end
        @(posedge clk);
        #1;
        chk("rst_no_done", 32'(a_clr_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 0, 0, 3, 4, 1'b0);
        tick_edge();
        fill_a5();
        set_in(1'b0, 0, 0, 15, 2, 1'b1);
        tick_check();
        tick_edge();
        run_sweep(1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                   int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, D - 1)),
                   int'($urandom_range(0, D - 1)), $urandom_range(0, 15) == 0);
            tick_check();
            tick_edge();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
